// File: rtl/prince_decrypt.sv
// Iterative PRINCE block decryptor: one round per clock, 12-edge latency from accept to done.
// Runs the PRINCE core with k1^ALPHA and swaps the whitening keys (k0' in, k0 out).
module prince_decrypt #(
    parameter logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [63:0]  ciphertext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [63:0]  plaintext
);

    typedef enum logic {IDLE, RUN} state_t;

    // S-box tables packed so that entry n sits at bits [4n +: 4].
    localparam logic [63:0] SBOX    = 64'h4d5e087619ca23fb;
    localparam logic [63:0] SBOXINV = 64'h1ce5046a98df237b;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_rnd;
    logic [63:0] r_st;
    logic [63:0] r_k0;
    logic [63:0] r_kd;
    logic [63:0] r_plaintext;
    logic        r_done;
    logic [63:0] w_k0Prime;
    logic [63:0] w_init;
    logic [63:0] w_sOut;
    logic [63:0] w_roundOut;

    function automatic logic [63:0] subNibbles(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv ? SBOXINV[4*x[4*n +: 4] +: 4] : SBOX[4*x[4*n +: 4] +: 4];
        end
        return y;
    endfunction

    // Each output bit is the XOR of the same bit position in three of the four input nibbles.
    function automatic logic [15:0] mHat(input logic [15:0] x, input int sel);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 4; b++) begin
                    if (((i + b + sel) % 4) != j) begin
                        y[15 - 4*i - j] = y[15 - 4*i - j] ^ x[15 - 4*b - j];
                    end
                end
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] mPrime(input logic [63:0] x);
        return {mHat(x[63:48], 0), mHat(x[47:32], 1), mHat(x[31:16], 1), mHat(x[15:0], 0)};
    endfunction

    // Nibble 0 is the most significant; forward picks nibble 5i, inverse picks 13i (mod 16).
    function automatic logic [63:0] shiftRows(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src = inv ? ((13 * i) % 16) : ((5 * i) % 16);
            y[60 - 4*i +: 4] = x[60 - 4*src +: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] rcConst(input logic [3:0] idx);
        case (idx)
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return 64'h0;
        endcase
    endfunction

    assign w_k0Prime = {key[64], key[127:65]} ^ {63'b0, key[127]};
    assign w_init    = ciphertext ^ w_k0Prime ^ key[63:0] ^ ALPHA ^ rcConst(4'd0);

    always_comb begin
        w_sOut     = subNibbles(r_st, 1'b0);
        w_roundOut = r_st;
        if (r_rnd <= 4'd5) begin
            w_roundOut = shiftRows(mPrime(w_sOut), 1'b0) ^ rcConst(r_rnd) ^ r_kd;
        end else if (r_rnd == 4'd6) begin
            w_roundOut = subNibbles(mPrime(w_sOut), 1'b1);
        end else begin
            w_roundOut = subNibbles(mPrime(shiftRows(r_st ^ r_kd ^ rcConst(r_rnd - 4'd1), 1'b1)), 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (r_rnd == 4'd11) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rnd       <= 4'd0;
            r_st        <= '0;
            r_k0        <= '0;
            r_kd        <= '0;
            r_plaintext <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_k0  <= key[127:64];
                    r_kd  <= key[63:0] ^ ALPHA;
                    r_st  <= w_init;
                    r_rnd <= 4'd1;
                end
            end else begin
                r_st <= w_roundOut;
                if (r_rnd == 4'd11) begin
                    r_plaintext <= w_roundOut ^ rcConst(4'd11) ^ r_kd ^ r_k0;
                    r_done      <= 1'b1;
                    r_rnd       <= 4'd0;
                end else begin
                    r_rnd <= r_rnd + 4'd1;
                end
            end
        end
    end

    assign done      = r_done;
    assign plaintext = r_plaintext;

endmodule

// File: tb/tb_prince_decrypt.sv
// Directed bench for prince_decrypt using published PRINCE vectors and a queue of expected plaintexts.
module tb_prince_decrypt;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  ciphertext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [63:0]  plaintext;

    int          checks    = 0;
    int          errors    = 0;
    int          doneCount = 0;
    int          baseCount;
    logic [63:0] expQ[$];
    logic [63:0] discard;

    prince_decrypt dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request at a negedge; returns one negedge later (one cycle after the accepting edge).
    task automatic applyStimulus(input logic [63:0] c, input logic [127:0] k, input logic [63:0] exp);
        ciphertext = c;
        key        = k;
        start      = 1'b1;
        expQ.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; latency counted in cycles after the accepting edge, done cycle = 12.
    task automatic checkOutput(input string tag, input int startN);
        int n;
        n = startN;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd12);
        if (done === 1'b1) begin
            check({tag, " plaintext"}, plaintext, expQ.pop_front());
            check({tag, " busy at done"}, 64'(busy), 64'd0);
        end else if (expQ.size() > 0) begin
            discard = expQ.pop_front();
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ciphertext = '0;
        key        = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset plaintext", plaintext, 64'd0);

        // Start on the very first edge after reset release.
        reset = 1'b0;
        applyStimulus(64'h818665aa0d02dfda, 128'h0, 64'h0000000000000000);
        check("v1 busy", 64'(busy), 64'd1);
        checkOutput("v1", 1);

        @(negedge clk);
        applyStimulus(64'h604ae6ca03c20ada, 128'h0, 64'hffffffffffffffff);
        checkOutput("v2", 1);

        @(negedge clk);
        applyStimulus(64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'h0}, 64'h0);
        checkOutput("v3", 1);

        @(negedge clk);
        applyStimulus(64'h78a54cbe737bb7ef, {64'h0, 64'hffffffffffffffff}, 64'h0);
        checkOutput("v4", 1);

        @(negedge clk);
        applyStimulus(64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 64'h0123456789abcdef);
        checkOutput("v5", 1);

        // Second start and input changes during RUN must not disturb the result.
        @(negedge clk);
        baseCount = doneCount;
        applyStimulus(64'h604ae6ca03c20ada, 128'h0, 64'hffffffffffffffff);
        @(negedge clk);
        ciphertext = {$urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        ciphertext = {$urandom, $urandom};
        @(negedge clk);
        checkOutput("midrun", 4);
        repeat (14) @(negedge clk);
        #1;
        check("midrun done count", 64'(doneCount - baseCount), 64'd1);

        // Back-to-back: next start issued in the done cycle.
        @(negedge clk);
        applyStimulus(64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'h0}, 64'h0);
        checkOutput("b2b first", 1);
        applyStimulus(64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 64'h0123456789abcdef);
        checkOutput("b2b second", 1);

        // Plaintext holds in IDLE while inputs wander.
        ciphertext = {$urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
        repeat (5) @(negedge clk);
        check("hold plaintext", plaintext, 64'h0123456789abcdef);
        check("hold done", 64'(done), 64'd0);

        // Abort with reset while rnd=6.
        applyStimulus(64'h604ae6ca03c20ada, 128'h0, 64'hffffffffffffffff);
        repeat (5) @(negedge clk);
        check("abort busy before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort plaintext", plaintext, 64'd0);
        reset     = 1'b0;
        discard   = expQ.pop_front();
        baseCount = doneCount;
        repeat (15) @(negedge clk);
        #1;
        check("abort no done", 64'(doneCount - baseCount), 64'd0);

        @(negedge clk);
        applyStimulus(64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 64'h0123456789abcdef);
        checkOutput("after abort", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
